// File: rtl/rmw_sequencer.sv
// rmw_sequencer: drives read, ALU modify, dummy write and final write for 6502 read-modify-write ops.
module rmw_sequencer #(
    parameter int ADDR_W = 16,
    parameter int MODE_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic              carry_in,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic              carry_out,
    output logic              zero,
    output logic              negative,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [MODE_W-1:0] alu_mode,
    output logic              alu_cin,
    input  logic [7:0]        alu_res,
    input  logic              alu_cout
);
    // Mode codes shared with the ALU; pass-through is 0 so an idle sequencer drives all-zero ALU inputs.
    localparam logic [MODE_W-1:0] M_PASS = MODE_W'(0);
    localparam logic [MODE_W-1:0] M_ADC  = MODE_W'(1);
    localparam logic [MODE_W-1:0] M_SBC  = MODE_W'(2);
    localparam logic [MODE_W-1:0] M_ASL  = MODE_W'(3);
    localparam logic [MODE_W-1:0] M_ROL  = MODE_W'(4);
    localparam logic [MODE_W-1:0] M_LSR  = MODE_W'(5);
    localparam logic [MODE_W-1:0] M_ROR  = MODE_W'(6);

    typedef enum logic [2:0] {IDLE, READ, MODIFY, WRITE_ORIG, WRITE_NEW} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cin_q;
    logic [7:0]        opnd;
    logic [7:0]        new_val;
    logic              new_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_q      <= 3'd6;
            addr_q    <= '0;
            cin_q     <= 1'b0;
            opnd      <= 8'd0;
            new_val   <= 8'd0;
            new_c     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 8'd0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    op_q   <= op;
                    addr_q <= addr;
                    cin_q  <= carry_in;
                    busy   <= 1'b1;
                    state  <= READ;
                end
                READ: if (mem_ready) begin
                    opnd  <= mem_rdata;
                    state <= MODIFY;
                end
                MODIFY: begin
                    new_val <= alu_res;
                    new_c   <= !op_q[2] ? alu_cout : cin_q;
                    state   <= WRITE_ORIG;
                end
                WRITE_ORIG: if (mem_ready) state <= WRITE_NEW;
                WRITE_NEW: if (mem_ready) begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    result    <= new_val;
                    carry_out <= new_c;
                    zero      <= new_val == 8'd0;
                    negative  <= new_val[7];
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_rd    = state == READ;
        mem_wr    = state == WRITE_ORIG || state == WRITE_NEW;
        mem_wdata = state == WRITE_NEW ? new_val : opnd;
        alu_a     = opnd;
        alu_b     = (op_q == 3'd4 || op_q == 3'd5) ? 8'd1 : 8'd0;
        alu_cin   = op_q == 3'd4 ? 1'b0 : op_q == 3'd5 ? 1'b1 : cin_q;
        alu_mode  = op_q == 3'd0 ? M_ASL :
                    op_q == 3'd1 ? M_ROL :
                    op_q == 3'd2 ? M_LSR :
                    op_q == 3'd3 ? M_ROR :
                    op_q == 3'd4 ? M_ADC :
                    op_q == 3'd5 ? M_SBC : M_PASS;
    end
endmodule

// File: tb/tb_rmw_sequencer.sv
// tb_rmw_sequencer: scoreboard bench with a behavioural ALU and a memory with programmable wait states.
module tb_rmw_sequencer;
    localparam int AW = 16;
    localparam int MW = 5;
    localparam logic [MW-1:0] M_PASS = 5'd0, M_ADC = 5'd1, M_SBC = 5'd2, M_ASL = 5'd3,
                              M_ROL = 5'd4, M_LSR = 5'd5, M_ROR = 5'd6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'd0;
    logic [AW-1:0] addr = '0;
    logic          carry_in = 1'b0;
    logic          busy, done, carry_out, zero, negative, mem_rd, mem_wr, mem_ready, alu_cin, alu_cout;
    logic [7:0]    result, mem_wdata, alu_a, alu_b, alu_res;
    logic [7:0]    mem_rdata = 8'd0;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] alu_mode;

    int errors = 0;
    int checks = 0;
    int rd_wait = 0;
    int wr_wait = 0;
    int cnt = 0;

    typedef struct {
        logic [7:0] res;
        logic       c, z, n;
        logic [7:0] w0, w1;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] wq[$];

    rmw_sequencer #(.ADDR_W(AW), .MODE_W(MW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .addr(addr), .carry_in(carry_in),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
        .negative(negative), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_a(alu_a),
        .alu_b(alu_b), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_res(alu_res), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        {alu_cout, alu_res} = {1'b0, alu_a};
        case (alu_mode)
            M_ADC: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
            M_SBC: {alu_cout, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'(alu_cin);
            M_ASL: {alu_cout, alu_res} = {alu_a, 1'b0};
            M_ROL: {alu_cout, alu_res} = {alu_a, alu_cin};
            M_LSR: {alu_res, alu_cout} = {1'b0, alu_a};
            M_ROR: {alu_res, alu_cout} = {alu_cin, alu_a};
            default: ;
        endcase
    end

    always_comb mem_ready = mem_rd ? (cnt >= rd_wait) : mem_wr ? (cnt >= wr_wait) : 1'b1;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= 0;
        else cnt <= ((mem_rd || mem_wr) && !mem_ready) ? cnt + 1 : 0;

    always @(posedge clk)
        if (reset_n && mem_wr && mem_ready) wq.push_back(mem_wdata);

    // Scoreboard: every done pops one expected transaction and its two bus writes.
    always @(negedge clk) begin
        if (reset_n && done) begin
            checks++;
            if (sb.size() == 0 || wq.size() < 2) begin
                errors++;
                $display("FAIL sb_txn: done with %0d expected entries and %0d writes, required >=1 and >=2",
                         sb.size(), wq.size());
            end else begin
                exp_t e;
                logic [7:0] w0, w1;
                e  = sb.pop_front();
                w0 = wq.pop_front();
                w1 = wq.pop_front();
                checks += 6;
                if (result !== e.res) begin errors++; $display("FAIL result: got %h need %h", result, e.res); end
                if (carry_out !== e.c) begin errors++; $display("FAIL carry_out: got %b need %b", carry_out, e.c); end
                if (zero !== e.z) begin errors++; $display("FAIL zero: got %b need %b", zero, e.z); end
                if (negative !== e.n) begin errors++; $display("FAIL negative: got %b need %b", negative, e.n); end
                if (w0 !== e.w0) begin errors++; $display("FAIL write_orig: got %h need %h", w0, e.w0); end
                if (w1 !== e.w1) begin errors++; $display("FAIL write_new: got %h need %h", w1, e.w1); end
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge (edge 0).
    task automatic launch(input logic [2:0] o, input logic [AW-1:0] a, input logic c, input logic [7:0] d);
        exp_t e;
        logic [7:0] r;
        logic rc;
        case (o)
            3'd0: {rc, r} = {d, 1'b0};
            3'd1: {rc, r} = {d, c};
            3'd2: {r, rc} = {1'b0, d};
            3'd3: {r, rc} = {c, d};
            3'd4: begin r = d + 8'd1; rc = c; end
            3'd5: begin r = d - 8'd1; rc = c; end
            default: begin r = d; rc = c; end
        endcase
        e.res = r; e.c = rc; e.z = (r == 8'd0); e.n = r[7]; e.w0 = d; e.w1 = r;
        sb.push_back(e);
        start = 1'b1; op = o; addr = a; carry_in = c; mem_rdata = d;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done) begin
            errors++; checks++;
            $display("FAIL timeout: no done within %0d cycles", n);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks += 3;
        if ({busy, done, mem_rd, mem_wr} !== 4'b0) begin errors++; $display("FAIL reset_ctl: got %b need 0000", {busy, done, mem_rd, mem_wr}); end
        if ({result, carry_out, zero, negative, mem_addr, mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_data: got %h need 0", {result, carry_out, zero, negative, mem_addr, mem_wdata});
        end
        if ({alu_a, alu_b, alu_mode, alu_cin} !== '0) begin errors++; $display("FAIL reset_alu: got %h need 0", {alu_a, alu_b, alu_mode, alu_cin}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_asl;
        launch(3'd0, 16'h0010, 1'b0, 8'h80);
        @(negedge clk);
        checks += 2;
        if ({mem_rd, mem_wr, busy} !== 3'b101) begin errors++; $display("FAIL asl_read: rd/wr/busy got %b need 101", {mem_rd, mem_wr, busy}); end
        if (mem_addr !== 16'h0010) begin errors++; $display("FAIL asl_addr: got %h need 0010", mem_addr); end
        @(negedge clk);
        checks += 2;
        if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL asl_modify_bus: got %b need 00", {mem_rd, mem_wr}); end
        if ({alu_mode, alu_a, alu_b} !== {M_ASL, 8'h80, 8'h00}) begin errors++; $display("FAIL asl_alu: got %h need %h", {alu_mode, alu_a, alu_b}, {M_ASL, 8'h80, 8'h00}); end
        @(negedge clk);
        checks++;
        if ({mem_wr, mem_wdata} !== {1'b1, 8'h80}) begin errors++; $display("FAIL asl_wr_orig: got %h need 180", {mem_wr, mem_wdata}); end
        @(negedge clk);
        checks++;
        if ({mem_wr, mem_wdata} !== {1'b1, 8'h00}) begin errors++; $display("FAIL asl_wr_new: got %h need 100", {mem_wr, mem_wdata}); end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL asl_done_c5: done/busy got %b need 10", {done, busy}); end
    endtask

    task automatic test_inc;
        int n;
        launch(3'd4, 16'h01FF, 1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_mode, alu_b, alu_cin, alu_a} !== {M_ADC, 8'h01, 1'b0, 8'hFF}) begin
            errors++; $display("FAIL inc_alu: got %h need %h", {alu_mode, alu_b, alu_cin, alu_a}, {M_ADC, 8'h01, 1'b0, 8'hFF});
        end
        wait_done(n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL inc_latency: done %0d cycles after modify check, need 3", n); end
        @(negedge clk);
        launch(3'd4, 16'h0100, 1'b0, 8'hFF);
        wait_done(n);
    endtask

    task automatic test_dec;
        int n, bad_addr, bad_wd;
        rd_wait = 2; wr_wait = 1;
        bad_addr = 0; bad_wd = 0;
        launch(3'd5, 16'h0000, 1'b1, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if ((mem_rd || mem_wr) && mem_addr !== 16'h0000) bad_addr++;
            if ((n == 5 || n == 6) && {mem_wr, mem_wdata} !== {1'b1, 8'h00}) bad_wd++;
            if ((n == 7 || n == 8) && {mem_wr, mem_wdata} !== {1'b1, 8'hFF}) bad_wd++;
            if (n == 4) begin
                checks++;
                if ({alu_mode, alu_b, alu_cin} !== {M_SBC, 8'h01, 1'b1}) begin
                    errors++; $display("FAIL dec_alu: got %h need %h", {alu_mode, alu_b, alu_cin}, {M_SBC, 8'h01, 1'b1});
                end
            end
        end while (!done && n < 40);
        checks += 3;
        if (n !== 9) begin errors++; $display("FAIL dec_latency: done in cycle %0d need 9", n); end
        if (bad_addr !== 0) begin errors++; $display("FAIL dec_addr_stable: %0d bad cycles need 0", bad_addr); end
        if (bad_wd !== 0) begin errors++; $display("FAIL dec_wdata_stable: %0d bad cycles need 0", bad_wd); end
        rd_wait = 0; wr_wait = 0;
    endtask

    task automatic test_shifts;
        int n;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            launch(3'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 8'($urandom));
            wait_done(n);
            checks++;
            if (n !== 5) begin errors++; $display("FAIL shift_latency: iter %0d done in cycle %0d need 5", i, n); end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        @(negedge clk);
        launch(3'd0, 16'h0020, 1'b0, 8'h01);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd2; addr = 16'h7777;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done_c5: done/busy got %b need 10", {done, busy}); end
        launch(3'd2, 16'h0030, 1'b0, 8'h03);
        @(negedge clk);
        checks++;
        if ({mem_rd, busy, mem_addr} !== {2'b11, 16'h0030}) begin
            errors++; $display("FAIL b2b_read: got %h need %h", {mem_rd, busy, mem_addr}, {2'b11, 16'h0030});
        end
        wait_done(n);
        repeat (6) @(negedge clk);
        checks++;
        if ({busy, mem_rd, mem_wr} !== 3'b000) begin errors++; $display("FAIL b2b_idle: got %b need 000", {busy, mem_rd, mem_wr}); end
    endtask

    task automatic test_reset_abort;
        int n;
        @(negedge clk);
        launch(3'd3, 16'h0040, 1'b1, 8'h81);
        repeat (3) @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1) begin errors++; $display("FAIL abort_setup: mem_wr got %b need 1", mem_wr); end
        reset_n = 1'b0;
        #1;
        checks += 2;
        if ({mem_wr, mem_rd, busy, done} !== 4'b0) begin errors++; $display("FAIL abort_async: wr/rd/busy/done got %b need 0000", {mem_wr, mem_rd, busy, done}); end
        if ({result, carry_out, zero, negative, mem_addr, mem_wdata, alu_a, alu_b, alu_mode, alu_cin} !== '0) begin
            errors++; $display("FAIL abort_outputs: got %h need 0", {result, carry_out, zero, negative, mem_addr, mem_wdata, alu_a, alu_b, alu_mode, alu_cin});
        end
        void'(sb.pop_back());
        wq.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        launch(3'd6, 16'h0050, 1'b1, 8'h5A);
        wait_done(n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL pass_latency: done in cycle %0d need 5", n); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_asl();
        test_inc();
        test_dec();
        test_shifts();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || wq.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d expected and %0d writes left, need 0", sb.size(), wq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
